mc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the MIPS CPU core. It replaces the purely combinational controller of the single-cycle core with a Moore FSM. The FSM steps every instruction through FETCH / DECODE / execute / memory / write-back cycles, so the ifu, RegFile, ALU and DM can share one ALU and one memory port. It sits between GetCode (OpCode/func in) and the datapath write enables and mux selects.

---
 rtl/mc_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle Moore control sequencer for the MIPS core.
// Steps each instruction through fetch/decode/exec/mem/wb.
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       Mem_to_Reg,
  output logic       nPC_sel,
  output logic       J,
  output logic       jal,
  output logic       jr,
  output logic [1:0] RegDst,
  output logic [1:0] Extop,
  output logic [2:0] ALUop,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXE     = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic [5:0] r_fn;
  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_rtype;
  logic       w_addu;
  logic       w_subu;
  logic       w_jr;
  logic       w_ori;
  logic       w_lui;
  logic       w_addi;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;
  logic       w_j;
  logic       w_jal;

  // In DECODE use the live IR fields; afterwards the copy
  // latched at the end of DECODE.
  assign w_op = (r_state == S_DECODE) ? OpCode : r_op;
  assign w_fn = (r_state == S_DECODE) ? func   : r_fn;

  assign w_rtype = (w_op == OP_R);
  assign w_addu  = w_rtype && (w_fn == FN_ADDU);
  assign w_subu  = w_rtype && (w_fn == FN_SUBU);
  assign w_jr    = w_rtype && (w_fn == FN_JR);
  assign w_ori   = (w_op == OP_ORI);
  assign w_lui   = (w_op == OP_LUI);
  assign w_addi  = (w_op == OP_ADDI);
  assign w_lw    = (w_op == OP_LW);
  assign w_sw    = (w_op == OP_SW);
  assign w_beq   = (w_op == OP_BEQ);
  assign w_j     = (w_op == OP_J);
  assign w_jal   = (w_op == OP_JAL);

  assign state = r_state;

  // State register; instruction fields captured while in DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= 6'd0;
      r_fn    <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= OpCode;
        r_fn <= func;
      end
    end
  end

  // Next-state and Moore outputs; reset masks every enable.
  always_comb begin
    w_next     = S_FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    Mem_to_Reg = 1'b0;
    nPC_sel    = 1'b0;
    J          = 1'b0;
    jal        = 1'b0;
    jr         = 1'b0;
    RegDst     = 2'b00;
    Extop      = 2'b00;
    ALUop      = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        if (w_addu || w_subu || w_ori || w_lui || w_addi)
          w_next = S_EXE;
        else if (w_jr || w_j || w_jal)
          w_next = S_JUMP;
        else if (w_lw || w_sw)
          w_next = S_MEM_ADR;
        else if (w_beq)
          w_next = S_BRANCH;
        else begin
          w_next     = S_FETCH;
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_EXE: begin
        w_next = S_ALU_WB;
        if (w_subu) begin
          ALUop = 3'b001;
        end else if (w_ori) begin
          ALUop  = 3'b010;
          ALUSrc = 1'b1;
        end else if (w_lui) begin
          ALUop  = 3'b010;
          ALUSrc = 1'b1;
          Extop  = 2'b10;
        end else if (w_addi) begin
          ALUSrc = 1'b1;
          Extop  = 2'b01;
        end
      end
      S_ALU_WB: begin
        RegWrite   = !(w_addi && overflow);
        RegDst     = w_rtype ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      S_MEM_ADR: begin
        ALUSrc = 1'b1;
        Extop  = 2'b01;
        w_next = w_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        Mem_to_Reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUop      = 3'b001;
        nPC_sel    = 1'b1;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        if (w_jal) begin
          J        = 1'b1;
          jal      = 1'b1;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
        end else if (w_j) begin
          J = 1'b1;
        end else begin
          jr = 1'b1;
        end
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ALUSrc     = 1'b0;
      Mem_to_Reg = 1'b0;
      nPC_sel    = 1'b0;
      J          = 1'b0;
      jal        = 1'b0;
      jr         = 1'b0;
      RegDst     = 2'b00;
      Extop      = 2'b00;
      ALUop      = 3'b000;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected
// output words are queued by the driver, popped by a monitor.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OpCode = 6'h3f;
  logic [5:0] func = 6'h3f;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite;
  logic       ALUSrc, Mem_to_Reg, nPC_sel, J, jal, jr;
  logic [1:0] RegDst, Extop;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic       instr_done, illegal;

  logic [22:0] q[$];
  logic [22:0] w_obs;
  int          checks = 0;
  int          errors = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .func(func),
    .zero(zero), .overflow(overflow), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .Mem_to_Reg(Mem_to_Reg), .nPC_sel(nPC_sel),
    .J(J), .jal(jal), .jr(jr), .RegDst(RegDst), .Extop(Extop),
    .ALUop(ALUop), .state(state), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign w_obs = {state, PCWrite, IRWrite, RegWrite, MemWrite,
                  ALUSrc, Mem_to_Reg, nPC_sel, J, jal, jr,
                  RegDst, Extop, ALUop, instr_done, illegal};

  function automatic logic [22:0] ev(
    input logic [3:0] st, input logic pcw, irw, rw, mw,
    input logic src, m2r, npc, jj, jl, jrr,
    input logic [1:0] rd, ext, input logic [2:0] alu,
    input logic done, ill);
    return {st, pcw, irw, rw, mw, src, m2r, npc, jj, jl, jrr,
            rd, ext, alu, done, ill};
  endfunction

  logic [22:0] V_RST, V_F, V_D, V_ILL, V_MADR;

  // Drive one cycle of inputs just after the edge, queue its expectation.
  task automatic step(input logic rst, input logic [5:0] op, fn,
                      input logic z, ov, input logic [22:0] e);
    @(posedge clk);
    #1;
    reset = rst; OpCode = op; func = fn; zero = z; overflow = ov;
    q.push_back(e);
  endtask

  // Monitor: compare the DUT word mid-cycle against the queue head.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (w_obs !== e) begin
          errors++;
          $display("FAIL cyc_%0d state=%0d got=%h exp=%h",
                   checks, state, w_obs, e);
        end
      end
    end
  end

  initial begin
    V_RST  = ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    V_F    = ev(0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    V_D    = ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    V_ILL  = ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1);
    V_MADR = ev(3,0,0,0,0,1,0,0,0,0,0,0,1,0,0,0);

    repeat (3) step(1, 6'h3f, 6'h3f, 0, 0, V_RST);

    // addu: 0,1,2,7
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h00, 6'h21, 0, 0, V_D);
    step(0, 6'h00, 6'h21, 0, 0, ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step(0, 6'h00, 6'h21, 0, 0, ev(7,0,0,1,0,0,0,0,0,0,0,1,0,0,1,0));
    // subu
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h00, 6'h23, 0, 0, V_D);
    step(0, 6'h00, 6'h23, 0, 0, ev(2,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    step(0, 6'h00, 6'h23, 0, 0, ev(7,0,0,1,0,0,0,0,0,0,0,1,0,0,1,0));
    // lw: 0,1,3,4,5
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h23, 6'h00, 0, 0, V_D);
    step(0, 6'h23, 6'h00, 0, 0, V_MADR);
    step(0, 6'h23, 6'h00, 0, 0, ev(4,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step(0, 6'h23, 6'h00, 0, 0, ev(5,0,0,1,0,0,1,0,0,0,0,0,0,0,1,0));
    // sw: 0,1,3,6
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h2b, 6'h00, 0, 0, V_D);
    step(0, 6'h2b, 6'h00, 0, 0, V_MADR);
    step(0, 6'h2b, 6'h00, 0, 0, ev(6,0,0,0,1,0,0,0,0,0,0,0,0,0,1,0));
    // beq taken / not taken
    step(0, 6'h3f, 6'h3f, 1, 0, V_F);
    step(0, 6'h04, 6'h00, 1, 0, V_D);
    step(0, 6'h04, 6'h00, 1, 0, ev(8,1,0,0,0,0,0,1,0,0,0,0,0,1,1,0));
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h04, 6'h00, 0, 0, V_D);
    step(0, 6'h04, 6'h00, 0, 0, ev(8,0,0,0,0,0,0,1,0,0,0,0,0,1,1,0));
    // jal
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h03, 6'h00, 0, 0, V_D);
    step(0, 6'h03, 6'h00, 0, 0, ev(9,1,0,1,0,0,0,0,1,1,0,2,0,0,1,0));
    // jr
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h00, 6'h08, 0, 0, V_D);
    step(0, 6'h00, 6'h08, 0, 0, ev(9,1,0,0,0,0,0,0,0,0,1,0,0,0,1,0));
    // j
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h02, 6'h00, 0, 0, V_D);
    step(0, 6'h02, 6'h00, 0, 0, ev(9,1,0,0,0,0,0,0,1,0,0,0,0,0,1,0));
    // ori
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h0d, 6'h00, 0, 0, V_D);
    step(0, 6'h0d, 6'h00, 0, 0, ev(2,0,0,0,0,1,0,0,0,0,0,0,0,2,0,0));
    step(0, 6'h0d, 6'h00, 0, 1, ev(7,0,0,1,0,0,0,0,0,0,0,0,0,0,1,0));
    // lui
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h0f, 6'h00, 0, 0, V_D);
    step(0, 6'h0f, 6'h00, 0, 0, ev(2,0,0,0,0,1,0,0,0,0,0,0,2,2,0,0));
    step(0, 6'h0f, 6'h00, 0, 0, ev(7,0,0,1,0,0,0,0,0,0,0,0,0,0,1,0));
    // addi with and without overflow
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h08, 6'h00, 0, 0, V_D);
    step(0, 6'h08, 6'h00, 0, 0, ev(2,0,0,0,0,1,0,0,0,0,0,0,1,0,0,0));
    step(0, 6'h08, 6'h00, 0, 1, ev(7,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h08, 6'h00, 0, 0, V_D);
    step(0, 6'h08, 6'h00, 0, 0, ev(2,0,0,0,0,1,0,0,0,0,0,0,1,0,0,0));
    step(0, 6'h08, 6'h00, 0, 0, ev(7,0,0,1,0,0,0,0,0,0,0,0,0,0,1,0));
    // illegal opcode, and unsupported R-type func
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h3f, 6'h00, 0, 0, V_ILL);
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h00, 6'h20, 0, 0, V_ILL);
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    // reset during MEM_WR of sw
    step(0, 6'h2b, 6'h00, 0, 0, V_D);
    step(0, 6'h2b, 6'h00, 0, 0, V_MADR);
    step(1, 6'h2b, 6'h00, 0, 0, ev(6,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step(0, 6'h3f, 6'h3f, 0, 0, V_F);
    step(0, 6'h02, 6'h00, 0, 0, V_D);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
